pmc_matrix_emu: RTL

Synthesizable emulator of the pixel matrix as seen from the PMC. It is the responder end of the matrix control interface: it consumes clkSh, shA, shB, gate, strobe, write_cfg and the per-column dout bits, and returns the per-column din bits. It stands in for the analog/digital matrix in FPGA prototypes and SoC-level simulation, so PMCC firmware can run counter readout and configuration load against a deterministic model.

---
 rtl/pmc_matrix_emu.sv | 114 +++++++++++
 1 files changed

// File: rtl/pmc_matrix_emu.sv
// Responder-side model of the pixel matrix: per-column counter and config chains
// driven by the PMC shift/strobe/config controls, all sampled on the single clk.
module pmc_matrix_emu #(
   parameter int COLUMNS   = 16,
   parameter int PIXELS    = 8,
   parameter int CNT_WIDTH = 8,
   parameter int CFG_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clkSh,
   input  logic               shA,
   input  logic               shB,
   input  logic               gate,
   input  logic               strobe,
   input  logic               write_cfg,
   input  logic [COLUMNS-1:0] dout,
   output logic [COLUMNS-1:0] din,
   output logic               err
);

   localparam int SH_WIDTH = PIXELS * CFG_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   // Mode is the concatenation {shA, shB}.
   typedef enum logic [1:0] {
      MODE_IDLE      = 2'b00,
      MODE_CFG_SHIFT = 2'b01,
      MODE_CNT_SHIFT = 2'b10,
      MODE_ILLEGAL   = 2'b11
   } mode_t;

   mode_t mode;

   logic [CNT_WIDTH-1:0] cnt     [COLUMNS][PIXELS];
   logic [CFG_WIDTH-1:0] cfg     [COLUMNS][PIXELS];
   logic [SH_WIDTH-1:0]  shadow  [COLUMNS];
   logic [PIXELS-1:0]    cnt_link [COLUMNS];

   logic clk_sh_q, strobe_q, write_cfg_q;
   logic sh_rise, strobe_rise, cfg_rise;
   logic cnt_shift, cfg_shift, cnt_inc;

   assign mode        = mode_t'({shA, shB});
   assign sh_rise     = clkSh & ~clk_sh_q;
   assign strobe_rise = strobe & ~strobe_q;
   assign cfg_rise    = write_cfg & ~write_cfg_q;
   assign cnt_shift   = sh_rise && (mode == MODE_CNT_SHIFT);
   assign cfg_shift   = sh_rise && (mode == MODE_CFG_SHIFT);
   assign cnt_inc     = strobe_rise && gate && (mode == MODE_IDLE);

   // Serial input of each pixel in the counter chain: dout for pixel 0,
   // otherwise the MSB of the pixel below.
   always_comb begin
      for (int c = 0; c < COLUMNS; c++) begin
         cnt_link[c][0] = dout[c];
         for (int k = 1; k < PIXELS; k++) begin
            cnt_link[c][k] = cnt[c][k-1][CNT_WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sh_q    <= 1'b0;
         strobe_q    <= 1'b0;
         write_cfg_q <= 1'b0;
         err         <= 1'b0;
         for (int c = 0; c < COLUMNS; c++) begin
            shadow[c] <= '0;
            for (int k = 0; k < PIXELS; k++) begin
               cnt[c][k] <= '0;
               cfg[c][k] <= '0;
            end
         end
      end else begin
         clk_sh_q    <= clkSh;
         strobe_q    <= strobe;
         write_cfg_q <= write_cfg;
         if (sh_rise && (mode == MODE_ILLEGAL)) begin
            err <= 1'b1;
         end
         for (int c = 0; c < COLUMNS; c++) begin
            if (cfg_shift) begin
               shadow[c] <= {shadow[c][SH_WIDTH-2:0], dout[c]};
            end
            for (int k = 0; k < PIXELS; k++) begin
               // cfg sees the pre-shift shadow when a shift lands in the same cycle.
               if (cfg_rise) begin
                  cfg[c][k] <= shadow[c][k*CFG_WIDTH +: CFG_WIDTH];
               end
               if (cnt_shift) begin
                  cnt[c][k] <= {cnt[c][k][CNT_WIDTH-2:0], cnt_link[c][k]};
               end else if (cnt_inc && cfg[c][k][0] && (cnt[c][k] != CNT_MAX)) begin
                  cnt[c][k] <= cnt[c][k] + CNT_WIDTH'(1);
               end
            end
         end
      end
   end

   always_comb begin
      din = '0;
      for (int c = 0; c < COLUMNS; c++) begin
         unique case (mode)
            MODE_IDLE,
            MODE_CNT_SHIFT: din[c] = cnt[c][PIXELS-1][CNT_WIDTH-1];
            MODE_CFG_SHIFT: din[c] = shadow[c][SH_WIDTH-1];
            default:        din[c] = 1'b0;
         endcase
      end
   end

endmodule
